// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the ID/EX hazard controller: opcode values,
// EX-unit operation encodings, controller state enum and the instruction
// field positions inside the 32-bit IR.
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

  // Opcodes (IR[31:28]); anything else is a NOP with no sources/destination
  localparam logic [3:0] OP_LW    = 4'd0;
  localparam logic [3:0] OP_SW    = 4'd1;
  localparam logic [3:0] OP_LI    = 4'd2;
  localparam logic [3:0] OP_ADDU  = 4'd3;
  localparam logic [3:0] OP_ADDIU = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_MUL   = 4'd6;
  localparam logic [3:0] OP_BGE   = 4'd7;
  localparam logic [3:0] OP_J     = 4'd8;
  localparam logic [3:0] OP_MULI  = 4'd9;

  // Operation selected in the EX unit
  typedef enum logic [1:0] {
    EX_ADD = 2'd0,
    EX_MUL = 2'd1,
    EX_SLL = 2'd2,
    EX_BGE = 2'd3
  } ex_op_e;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_MUL_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_e;

  // Low bit of each IR field
  localparam int OPC_LSB = 28;
  localparam int RD_LSB  = 24;
  localparam int RS_LSB  = 20;
  localparam int RT_LSB  = 16;

  // EX operation implied by an opcode (address/immediate ops use the adder)
  function automatic ex_op_e ex_op_of(input logic [3:0] opc);
    ex_op_e op_v;
    case (opc)
      OP_MUL, OP_MULI: op_v = EX_MUL;
      OP_SLL:          op_v = EX_SLL;
      OP_BGE:          op_v = EX_BGE;
      default:         op_v = EX_ADD;
    endcase
    return op_v;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Decode-side bundle between the pipeline and the hazard controller.
//   id_ir_i / id_valid_i : instruction in ID and its valid flag
//   br_taken_i           : BGE in EX resolved taken
//   stall_o, bubble_o, flush_o, fwd_sel_o, ex_busy_o : controller outputs
// With HAZ_PERF_CNT_EN defined, stall_cnt_o / flush_cnt_o are added.
// master = pipeline side, slave = controller.
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
  logic [31:0] id_ir_i;
  logic        id_valid_i;
  logic        br_taken_i;
  logic        stall_o;
  logic        bubble_o;
  logic        flush_o;
  logic [1:0]  fwd_sel_o;
  logic        ex_busy_o;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  modport master (
    output id_ir_i, id_valid_i, br_taken_i,
`ifdef HAZ_PERF_CNT_EN
    input  stall_cnt_o, flush_cnt_o,
`endif
    input  stall_o, bubble_o, flush_o, fwd_sel_o, ex_busy_o
  );

  modport slave (
    input  id_ir_i, id_valid_i, br_taken_i,
`ifdef HAZ_PERF_CNT_EN
    output stall_cnt_o, flush_cnt_o,
`endif
    output stall_o, bubble_o, flush_o, fwd_sel_o, ex_busy_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl_insn_decode_info.sv
// ---------------------------------------------------------------------------
// insn_decode_info
// Purely combinational classification of one instruction word.
//   ir_i        : 32-bit instruction (only the opcode is inspected)
//   writes_rd_o : instruction writes rd
//   reads_rs_o  : instruction reads rs
//   reads_rt_o  : instruction reads rt
//   is_load_o   : LW
//   is_mul_o    : MUL or MULI
//   is_jump_o   : J
//   is_branch_o : BGE
// ---------------------------------------------------------------------------
module insn_decode_info
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic        writes_rd_o,
  output logic        reads_rs_o,
  output logic        reads_rt_o,
  output logic        is_load_o,
  output logic        is_mul_o,
  output logic        is_jump_o,
  output logic        is_branch_o
);

  logic [3:0] opc_s;
  logic       unused_ir_s;

  assign opc_s       = ir_i[OPC_LSB +: 4];
  assign unused_ir_s = ^ir_i[OPC_LSB-1:0];

  // Opcode to attribute table; unknown opcodes decode as a NOP
  always_comb begin
    writes_rd_o = 1'b0;
    reads_rs_o  = 1'b0;
    reads_rt_o  = 1'b0;
    is_load_o   = 1'b0;
    is_mul_o    = 1'b0;
    is_jump_o   = 1'b0;
    is_branch_o = 1'b0;
    case (opc_s)
      OP_LW:    begin writes_rd_o = 1'b1; reads_rs_o = 1'b1; is_load_o = 1'b1; end
      OP_SW:    begin reads_rs_o = 1'b1; reads_rt_o = 1'b1; end
      OP_LI:    begin writes_rd_o = 1'b1; end
      OP_ADDU:  begin writes_rd_o = 1'b1; reads_rs_o = 1'b1; reads_rt_o = 1'b1; end
      OP_ADDIU: begin writes_rd_o = 1'b1; reads_rs_o = 1'b1; end
      OP_SLL:   begin writes_rd_o = 1'b1; reads_rs_o = 1'b1; end
      OP_MUL:   begin writes_rd_o = 1'b1; reads_rs_o = 1'b1; reads_rt_o = 1'b1; is_mul_o = 1'b1; end
      OP_BGE:   begin reads_rs_o = 1'b1; reads_rt_o = 1'b1; is_branch_o = 1'b1; end
      OP_J:     begin is_jump_o = 1'b1; end
      OP_MULI:  begin writes_rd_o = 1'b1; reads_rs_o = 1'b1; is_mul_o = 1'b1; end
      default:  begin writes_rd_o = 1'b0; end
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard/forwarding controller for the ID/EX boundary.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   bus (slave)    : id_ir_i, id_valid_i, br_taken_i in;
//                    stall_o, bubble_o, flush_o, fwd_sel_o, ex_busy_o out
// Parameters: MUL_LAT (EX cycles of MUL/MULI, 1..7), REG_W (register index).
// Optional: HAZ_PERF_CNT_EN adds saturating stall/flush cycle counters.
// Flushes are signalled from the FLUSH state, the cycle after the jump or
// taken branch is seen; stall and forwarding are zero-latency from id_ir_i.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int REG_W   = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam logic [2:0] MUL_CNT_INIT = 3'(MUL_LAT - 1);
  localparam bit         MUL_MULTI    = (MUL_LAT > 1);

  state_e           state_r, state_nxt_s;
  logic [2:0]       cnt_r, cnt_nxt_s;
  logic             flush_bge_r, flush_bge_nxt_s;
  logic [REG_W-1:0] ex_rd_r, mem_rd_r;
  logic             ex_wr_r, ex_ld_r, mem_wr_r;

  logic [REG_W-1:0] rd_s, rs_s, rt_s;
  logic             dec_wr_s, dec_rs_s, dec_rt_s, dec_ld_s, dec_mul_s, dec_j_s, dec_br_s;
  logic             use_rs_s, use_rt_s, ld_hit_s, fwd_rs_s, fwd_rt_s, flush_req_s;
  logic             accept_s;
  logic             stall_s, bubble_s, flush_s, busy_s;
  logic [1:0]       fwd_s;
  logic             unused_s;

  insn_decode_info u_id_dec (
    .ir_i        (bus.id_ir_i),
    .writes_rd_o (dec_wr_s),
    .reads_rs_o  (dec_rs_s),
    .reads_rt_o  (dec_rt_s),
    .is_load_o   (dec_ld_s),
    .is_mul_o    (dec_mul_s),
    .is_jump_o   (dec_j_s),
    .is_branch_o (dec_br_s)
  );

  assign rd_s = bus.id_ir_i[RD_LSB +: REG_W];
  assign rs_s = bus.id_ir_i[RS_LSB +: REG_W];
  assign rt_s = bus.id_ir_i[RT_LSB +: REG_W];

  // MEM slot is tracked for visibility only: the write-first register file
  // resolves MEM-to-ID dependences without forwarding.
  assign unused_s = ^{mem_rd_r, mem_wr_r, dec_br_s};

  // A source only matters when it is really read and is not r0
  assign use_rs_s    = bus.id_valid_i & dec_rs_s & (rs_s != {REG_W{1'b0}});
  assign use_rt_s    = bus.id_valid_i & dec_rt_s & (rt_s != {REG_W{1'b0}});
  assign ld_hit_s    = ex_ld_r & ((use_rs_s & (rs_s == ex_rd_r)) | (use_rt_s & (rt_s == ex_rd_r)));
  assign fwd_rs_s    = ex_wr_r & ~ex_ld_r & use_rs_s & (rs_s == ex_rd_r);
  assign fwd_rt_s    = ex_wr_r & ~ex_ld_r & use_rt_s & (rt_s == ex_rd_r);
  assign flush_req_s = bus.br_taken_i | (bus.id_valid_i & dec_j_s);

  // State register: FSM state, MUL countdown and branch-flush flag
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r     <= ST_RUN;
      cnt_r       <= 3'd0;
      flush_bge_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      flush_bge_r <= flush_bge_nxt_s;
    end
  end

  // Next-state logic. LD_STALL shares RUN's evaluation: EX holds the stall
  // bubble there, so only the accept path (possibly into MUL_WAIT) can fire.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    flush_bge_nxt_s = 1'b0;
    accept_s        = 1'b0;
    case (state_r)
      ST_RUN, ST_LD_STALL: begin
        if (flush_req_s) begin
          state_nxt_s     = ST_FLUSH;
          flush_bge_nxt_s = bus.br_taken_i;
        end else if (ld_hit_s) begin
          state_nxt_s = ST_LD_STALL;
        end else begin
          accept_s = 1'b1;
          if (bus.id_valid_i && dec_mul_s && MUL_MULTI) begin
            state_nxt_s = ST_MUL_WAIT;
            cnt_nxt_s   = MUL_CNT_INIT;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
      end
      ST_MUL_WAIT: begin
        // Leave on the cycle the count reaches zero; br_taken_i is ignored
        if (cnt_r <= 3'd1) begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = 3'd0;
        end else begin
          state_nxt_s = ST_MUL_WAIT;
          cnt_nxt_s   = cnt_r - 3'd1;
        end
      end
      ST_FLUSH: begin
        state_nxt_s = ST_RUN;
      end
      default: begin
        state_nxt_s = ST_RUN;
        cnt_nxt_s   = 3'd0;
      end
    endcase
  end

  // Output decode from state plus the live ID compare
  always_comb begin
    stall_s  = 1'b0;
    bubble_s = 1'b0;
    flush_s  = 1'b0;
    busy_s   = 1'b0;
    fwd_s    = 2'b00;
    case (state_r)
      ST_RUN, ST_LD_STALL: begin
        if (flush_req_s) begin
          fwd_s = 2'b00;
        end else if (ld_hit_s) begin
          stall_s  = 1'b1;
          bubble_s = 1'b1;
        end else begin
          fwd_s = {fwd_rt_s, fwd_rs_s};
        end
      end
      ST_MUL_WAIT: begin
        stall_s = 1'b1;
        busy_s  = 1'b1;
      end
      ST_FLUSH: begin
        flush_s  = 1'b1;
        bubble_s = flush_bge_r;
      end
      default: begin
        stall_s = 1'b0;
      end
    endcase
  end

  // Scoreboard: EX slot loads the accepted instruction or a bubble, then
  // shifts into MEM; everything holds while a MUL occupies EX.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_rd_r  <= {REG_W{1'b0}};
      ex_wr_r  <= 1'b0;
      ex_ld_r  <= 1'b0;
      mem_rd_r <= {REG_W{1'b0}};
      mem_wr_r <= 1'b0;
    end else if (state_r != ST_MUL_WAIT) begin
      mem_rd_r <= ex_rd_r;
      mem_wr_r <= ex_wr_r;
      ex_rd_r  <= rd_s;
      ex_wr_r  <= accept_s & bus.id_valid_i & dec_wr_s;
      ex_ld_r  <= accept_s & bus.id_valid_i & dec_ld_s;
    end
  end

  assign bus.stall_o   = stall_s;
  assign bus.bubble_o  = bubble_s;
  assign bus.flush_o   = flush_s;
  assign bus.fwd_sel_o = fwd_s;
  assign bus.ex_busy_o = busy_s;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_r, flush_cnt_r;

  // Saturating counts of stall and flush cycles
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (flush_s && (flush_cnt_r != 32'hFFFF_FFFF)) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end
    end
  end

  assign bus.stall_cnt_o = stall_cnt_r;
  assign bus.flush_cnt_o = flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed vector table, hand-written reset/counter sequences, then random
// instruction streams compared against a behavioural pipeline model.
// Output vectors are packed {stall, bubble, flush, fwd_sel[1:0], ex_busy}.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int MUL_LAT = 3;

  // Opcode membership sets as bit masks over the 16 opcodes
  localparam int WR_SET = (1 << 0) + (1 << 2) + (1 << 3) + (1 << 4) + (1 << 5) + (1 << 6) + (1 << 9);
  localparam int RS_SET = (1 << 0) + (1 << 1) + (1 << 3) + (1 << 4) + (1 << 5) + (1 << 6) + (1 << 9) + (1 << 7);
  localparam int RT_SET = (1 << 1) + (1 << 3) + (1 << 6) + (1 << 7);

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  pipe_hazard_ctrl_if hz_if ();

  pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .REG_W(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    bit          v;
    bit          br;
    logic [5:0]  exp;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: contents of EX, remaining MUL stall cycles, pending flush
  bit m_ex_wr, m_ex_ld;
  int m_ex_rd;
  int m_mul_left;
  bit m_flush_pend, m_flush_br;

  function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int rt);
    return {4'(op), 4'(rd), 4'(rs), 4'(rt), 16'h0000};
  endfunction

  function automatic vec_t vec(input logic [31:0] ir, input bit v, input bit br, input logic [5:0] e);
    vec_t r;
    r.ir = ir; r.v = v; r.br = br; r.exp = e;
    return r;
  endfunction

  function automatic logic [5:0] outs();
    return {hz_if.stall_o, hz_if.bubble_o, hz_if.flush_o, hz_if.fwd_sel_o, hz_if.ex_busy_o};
  endfunction

  task automatic drive(input logic [31:0] ir, input bit v, input bit br);
    hz_if.id_ir_i    = ir;
    hz_if.id_valid_i = v;
    hz_if.br_taken_i = br;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (stall,bubble,flush,fwd1,fwd0,busy)", name, act, exp);
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_ex_wr = 1'b0; m_ex_ld = 1'b0; m_ex_rd = 0;
    m_mul_left = 0; m_flush_pend = 1'b0; m_flush_br = 1'b0;
  endtask

  // One clock of the model: returns this cycle's outputs, advances to the next
  task automatic model_cycle(input logic [31:0] ir, input bit v, input bit br, output logic [5:0] e);
    int op, rd, rs, rt;
    bit use_rs, use_rt;
    op = {28'd0, ir[31:28]};
    rd = {28'd0, ir[27:24]};
    rs = {28'd0, ir[23:20]};
    rt = {28'd0, ir[19:16]};
    use_rs = v && (((RS_SET >> op) & 1) != 0) && (rs != 0);
    use_rt = v && (((RT_SET >> op) & 1) != 0) && (rt != 0);
    e = 6'b000000;
    if (m_mul_left > 0) begin
      e = 6'b100001;
      m_mul_left--;
    end else if (m_flush_pend) begin
      e[3] = 1'b1;
      e[4] = m_flush_br;
      m_flush_pend = 1'b0;
      m_ex_wr = 1'b0; m_ex_ld = 1'b0;
    end else if (br || (v && op == 8)) begin
      m_flush_pend = 1'b1;
      m_flush_br = br;
      m_ex_wr = 1'b0; m_ex_ld = 1'b0;
    end else if (m_ex_ld && ((use_rs && rs == m_ex_rd) || (use_rt && rt == m_ex_rd))) begin
      e[5] = 1'b1;
      e[4] = 1'b1;
      m_ex_wr = 1'b0; m_ex_ld = 1'b0;
    end else begin
      e[1] = use_rs && m_ex_wr && !m_ex_ld && (rs == m_ex_rd);
      e[2] = use_rt && m_ex_wr && !m_ex_ld && (rt == m_ex_rd);
      m_ex_wr = v && (((WR_SET >> op) & 1) != 0);
      m_ex_ld = v && (op == 0);
      m_ex_rd = rd;
      if (v && (op == 6 || op == 9)) m_mul_left = MUL_LAT - 1;
    end
  endtask

  initial begin
    logic [5:0]  e;
    logic [31:0] ir;
    bit          v, br;
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    drive(32'h0, 1'b0, 1'b0);

    // Directed sequence, one row per cycle (opcodes: LW0 SW1 ADDU3 ADDIU4 MUL6 BGE7 J8)
    tbl.push_back(vec(mk(3, 3, 1, 2),   1, 0, 6'b000000)); // ADDU r3,r1,r2
    tbl.push_back(vec(mk(3, 4, 3, 5),   1, 0, 6'b000010)); // ADDU r4,r3,r5 -> fwd rs
    tbl.push_back(vec(mk(0, 2, 1, 0),   1, 0, 6'b000000)); // LW r2,(r1)
    tbl.push_back(vec(mk(3, 6, 1, 2),   1, 0, 6'b110000)); // load-use on rt
    tbl.push_back(vec(mk(3, 6, 1, 2),   1, 0, 6'b000000)); // retried, no forward
    tbl.push_back(vec(mk(6, 7, 1, 6),   1, 0, 6'b000100)); // MUL r7,r1,r6 -> fwd rt
    tbl.push_back(vec(mk(1, 0, 8, 7),   1, 0, 6'b100001)); // MUL_WAIT 1
    tbl.push_back(vec(mk(1, 0, 8, 7),   1, 0, 6'b100001)); // MUL_WAIT 2
    tbl.push_back(vec(mk(1, 0, 8, 7),   1, 0, 6'b000100)); // SW rt=r7 forwarded
    tbl.push_back(vec(mk(8, 0, 0, 0),   1, 0, 6'b000000)); // J detected
    tbl.push_back(vec(mk(3, 1, 2, 3),   0, 0, 6'b001000)); // FLUSH, no bubble
    tbl.push_back(vec(mk(7, 0, 1, 2),   1, 0, 6'b000000)); // BGE r1,r2
    tbl.push_back(vec(mk(8, 0, 0, 0),   1, 1, 6'b000000)); // J in ID, BGE taken
    tbl.push_back(vec(mk(3, 1, 2, 3),   0, 0, 6'b011000)); // FLUSH with bubble
    tbl.push_back(vec(mk(3, 5, 3, 3),   1, 0, 6'b000000)); // back in RUN
    tbl.push_back(vec(mk(4, 0, 1, 0),   1, 0, 6'b000000)); // ADDIU r0,r1
    tbl.push_back(vec(mk(3, 8, 0, 0),   1, 0, 6'b000000)); // reads r0: no forward
    tbl.push_back(vec(mk(3, 9, 8, 8),   1, 0, 6'b000110)); // both sources forwarded
    tbl.push_back(vec(mk(0, 10, 9, 0),  1, 0, 6'b000010)); // LW r10,(r9)
    tbl.push_back(vec(mk(1, 0, 10, 10), 1, 0, 6'b110000)); // load-use on both sources
    tbl.push_back(vec(mk(1, 0, 10, 10), 1, 0, 6'b000000)); // only one stall cycle
    tbl.push_back(vec(mk(3, 11, 10, 10), 0, 0, 6'b000000)); // invalid slot
    tbl.push_back(vec(mk(0, 12, 1, 0),  1, 0, 6'b000000)); // LW r12
    tbl.push_back(vec(mk(3, 1, 12, 12), 0, 0, 6'b000000)); // invalid: no hazard
    tbl.push_back(vec(mk(0, 13, 2, 0),  1, 0, 6'b000000)); // LW r13
    tbl.push_back(vec(mk(12, 0, 13, 13), 1, 0, 6'b000000)); // NOP opcode reads nothing

    #12;
    check("reset_outputs", outs(), 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ir, tbl[i].v, tbl[i].br);
      #3;
      check($sformatf("vec[%0d]", i), outs(), tbl[i].exp);
      step();
    end

    // Reset in the middle of MUL_WAIT
    drive(mk(6, 7, 1, 2), 1, 0);
    #3;
    check("mul_accept", outs(), 6'b000000);
    step();
    drive(mk(1, 0, 8, 7), 1, 0);
    #3;
    check("mul_wait_busy", outs(), 6'b100001);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", outs(), 6'b000000);
    step();
    check("held_reset_outputs", outs(), 6'b000000);
    rst_n = 1'b1;
    #3;
    check("after_reset_no_fwd", outs(), 6'b000000);
    step();

    // Load-use followed by a jump (one stall cycle, one flush cycle)
    drive(mk(0, 2, 1, 0), 1, 0);
    #3; check("lw2", outs(), 6'b000000); step();
    drive(mk(3, 6, 1, 2), 1, 0);
    #3; check("lu_stall", outs(), 6'b110000); step();
    #3; check("lu_release", outs(), 6'b000000); step();
    drive(mk(8, 0, 0, 0), 1, 0);
    #3; check("j_detect", outs(), 6'b000000); step();
    drive(32'h0, 0, 0);
    #3; check("j_flush", outs(), 6'b001000); step();
    #3; check("j_done", outs(), 6'b000000);
`ifdef HAZ_PERF_CNT_EN
    check32("stall_cnt", hz_if.stall_cnt_o, 32'd1);
    check32("flush_cnt", hz_if.flush_cnt_o, 32'd1);
`endif
    step();

    // Random streams against the model
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      ir = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 7)),
            4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 16'($urandom)};
      v  = ($urandom_range(0, 9) != 0);
      br = ($urandom_range(0, 11) == 0);
      drive(ir, v, br);
      model_cycle(ir, v, br, e);
      #3;
      check($sformatf("rand[%0d] ir=%h v=%0d br=%0d", c, ir, v, br), outs(), e);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequences the ID/EX pipeline register and the EX unit.
- Tracks in-flight destination registers and drives the two forwarding selects consumed at the ID/EX boundary.
- Stalls on load-use and multi-cycle MUL hazards; flushes on jumps and taken BGE.
- Sits beside the decode stage; its outputs gate the IF/ID and ID/EX register enables and the forwarding muxes.

Parameters:
- MUL_LAT, 3, EX cycles a MUL/MULI occupies (legal range 1..7).
- REG_W, 4, register-index width (16 architectural registers; r0 reads zero, never a hazard).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous, active-low reset
- id_ir_i  in  32  instruction currently in ID (opcode [31:28], rd [27:24], rs [23:20], rt [19:16])
- id_valid_i  in  1  id_ir_i holds a real instruction
- br_taken_i  in  1  BGE in EX resolved taken (valid only while a BGE is in EX)
- stall_o  out  1  hold PC and IF/ID; load a bubble into ID/EX
- bubble_o  out  1  ID/EX captures a NOP this cycle (stall or flush)
- flush_o  out  1  kill IF/ID contents
- fwd_sel_o  out  2  [0]: rs comes from EX result; [1]: second source comes from EX result
- ex_busy_o  out  1  multi-cycle MUL occupying EX

Behaviour:
- Opcodes: LW=0, SW=1, LI=2, ADDU=3, ADDIU=4, SLL=5, MUL=6, BGE=7, J=8, MULI=9. Any other opcode behaves as a NOP: no write, no sources.
- Writers of rd: LW, LI, ADDU, ADDIU, SLL, MUL, MULI.
- Readers of rs: LW, SW, ADDU, ADDIU, SLL, MUL, MULI, BGE.
- Readers of rt: SW, ADDU, MUL, BGE.
- Scoreboard: ex_rd / ex_wr / ex_ld register the instruction accepted into EX, and shift into mem_rd / mem_wr each non-stalled cycle.
- A bubble clears ex_wr. The MEM stage needs no action because the register file is write-first.
- FSM states: RUN, LD_STALL, MUL_WAIT, FLUSH. Reset state is RUN.
- In RUN, evaluated in priority order:
  - (a) br_taken_i, or J in ID: go to FLUSH, assert flush_o; bubble_o for BGE only.
  - (b) ID reads a register equal to ex_rd while ex_ld=1 and the register is not r0: assert stall_o and bubble_o for exactly 1 cycle; go to LD_STALL.
  - (c) Otherwise accept the instruction. fwd_sel_o[i]=1 when source i matches ex_rd with ex_wr=1, ex_ld=0, and the source is not r0.
- An accepted MUL/MULI with MUL_LAT>1 enters MUL_WAIT. Counter loads MUL_LAT-1.
- MUL_WAIT: stall_o=1, bubble_o=0, ID/EX held, ex_busy_o=1. Counter decrements each cycle. At 0, return to RUN; forwarding is then evaluated normally.
- LD_STALL: stall_o=0. Return to RUN the next cycle; the load is now in MEM and needs no forwarding.
- FLUSH: one cycle, flush_o=1, stall_o=0, then RUN.
- Simultaneous J in ID and taken BGE in EX: the BGE wins, and the J is flushed with it.
- br_taken_i during MUL_WAIT is impossible by construction and is ignored.
- A load-use hazard on both sources still stalls only 1 cycle.
- Reset mid-operation: all outputs and internal state clear immediately. stall_o=0, bubble_o=0, flush_o=0, fwd_sel_o=0, ex_busy_o=0, counter=0, scoreboard valid bits=0, state=RUN.
- id_valid_i=0: no hazards and no forwarding; the slot advances as a bubble.
- All outputs are registered-state decodes plus combinational compare of id_ir_i. Zero-cycle latency from id_ir_i to fwd_sel_o/stall_o.

Optional Feature:
- HAZ_PERF_CNT_EN adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
- stall_cnt_o increments every cycle stall_o=1; flush_cnt_o increments every cycle flush_o=1.
- Both counters saturate at all-ones and clear on reset.
- Without the macro these ports and counters do not exist; other behaviour is identical.

Decomposition:
- Shared package holds:
  - the opcode constants (LW..MULI)
  - the EX op encodings (ADD=0, MUL=1, SLL=2, BGE=3)
  - the FSM state enum
  - the instruction field position constants
- One sub-module, insn_decode_info: purely combinational; maps an IR to writes_rd, reads_rs, reads_rt, is_load, is_mul, is_jump, is_branch. It is instantiated once, for ID.

Test Plan:
- ADDU r3,r1,r2 then ADDU r4,r3,r5 → second cycle fwd_sel_o=2'b01, stall_o=0.
- LW r2 then ADDU r6,r1,r2 → stall_o=1 and bubble_o=1 for exactly 1 cycle, then fwd_sel_o=2'b00.
- MUL r7,r1,r2 with MUL_LAT=3 → ex_busy_o and stall_o high 2 cycles; next SW using r7 as rt gets fwd_sel_o=2'b10.
- BGE with br_taken_i=1 while J in ID → flush_o=1 and bubble_o=1 for one cycle, state back to RUN.
- ADDIU r0 then ADDU reading r0 → fwd_sel_o=0. rst_n_i low mid MUL_WAIT → all outputs 0 asynchronously, RUN after release.
- With HAZ_PERF_CNT_EN: load-use and then a J → stall_cnt_o=1, flush_cnt_o=1.
